// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fifo
//  Description : Synchronous single-clock byte FIFO (DEPTH entries) with
//                registered read data and count-decoded empty/full flags.
//                Optional macro FIFO_ERR_FLAGS_EN adds overflow/underflow
//                one-cycle pulses for rejected writes/reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_WIDTH-1:0]  fifo_cnt
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int                   ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT   = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_en;
    logic                  rd_en;

    // Flags come straight from the count register, so they never glitch.
    assign empty = (fifo_cnt == '0);
    assign full  = (fifo_cnt == FULL_CNT);

    // A write into a full FIFO is still taken when a read frees the head slot
    // on the same edge; a read is only taken when something is stored.
    assign wr_en = wr && (!full || rd);
    assign rd_en = rd && !empty;

    // Storage array: contents are never reset, writes are blocked during reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, count and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            data_out <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_en) begin
                // When full, wr_ptr == rd_ptr: the old head is read here
                // while the write above replaces it on the same edge.
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_WIDTH'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_WIDTH'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // One-cycle pulses flagging requests dropped because of fill state.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr && !wr_en;
            underflow <= rd && empty;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo
//  Description : Self-checking bench for fifo: phase table with hand-derived
//                end states, a data scoreboard queue, and directed sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic [3:0] fifo_cnt;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    fifo #(.DATA_WIDTH(8), .DEPTH(8), .CNT_WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .data_in  (data_in),
        .rd       (rd),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .fifo_cnt (fifo_cnt)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;

    // Reference state: stored bytes in order, expected read register.
    logic [7:0] sb[$];
    logic [7:0] exp_dout = 8'd0;
    logic       exp_ovf = 1'b0;
    logic       exp_udf = 1'b0;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        int         cycles;
        int         exp_cnt;   // hand-derived count after the phase
        logic [7:0] exp_dout;  // hand-derived data_out after the phase
    } phase_t;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_outputs();
        check("fifo_cnt", int'(fifo_cnt), sb.size());
        check("empty", int'(empty), int'(sb.size() == 0));
        check("full", int'(full), int'(sb.size() == 8));
        check("data_out", int'(data_out), int'(exp_dout));
`ifdef FIFO_ERR_FLAGS_EN
        check("overflow", int'(overflow), int'(exp_ovf));
        check("underflow", int'(underflow), int'(exp_udf));
`endif
    endtask

    // One clock with the given requests; reference updated after the edge.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        bit wa, ra;
        wr      = w;
        rd      = r;
        data_in = d;
        ra      = r && (sb.size() != 0);
        wa      = w && ((sb.size() < 8) || r);
        exp_ovf = w && !wa;
        exp_udf = r && (sb.size() == 0);
        @(posedge clk);
        #1;
        if (ra) exp_dout = sb.pop_front();
        if (wa) sb.push_back(d);
        check_outputs();
    endtask

    task automatic do_reset(input int n, input logic w, input logic r);
        rst = 1'b1;
        wr  = w;
        rd  = r;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sb.delete();
            exp_dout = 8'd0;
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
            check_outputs();
        end
        rst = 1'b0;
        wr  = 1'b0;
        rd  = 1'b0;
    endtask

    phase_t tbl[8];

    initial begin
        tbl[0] = '{wr: 1'b0, rd: 1'b0, din: 8'd0,  cycles: 10, exp_cnt: 0, exp_dout: 8'd0};
        tbl[1] = '{wr: 1'b1, rd: 1'b0, din: 8'd42, cycles: 20, exp_cnt: 8, exp_dout: 8'd0};
        tbl[2] = '{wr: 1'b0, rd: 1'b1, din: 8'd0,  cycles: 10, exp_cnt: 0, exp_dout: 8'd42};
        tbl[3] = '{wr: 1'b1, rd: 1'b0, din: 8'd30, cycles: 15, exp_cnt: 8, exp_dout: 8'd42};
        tbl[4] = '{wr: 1'b1, rd: 1'b0, din: 8'd55, cycles: 10, exp_cnt: 8, exp_dout: 8'd42};
        tbl[5] = '{wr: 1'b0, rd: 1'b1, din: 8'd0,  cycles: 5,  exp_cnt: 3, exp_dout: 8'd30};
        tbl[6] = '{wr: 1'b1, rd: 1'b0, din: 8'd87, cycles: 25, exp_cnt: 8, exp_dout: 8'd30};
        tbl[7] = '{wr: 1'b0, rd: 1'b1, din: 8'd0,  cycles: 15, exp_cnt: 0, exp_dout: 8'd87};

        do_reset(2, 1'b0, 1'b0);

        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < tbl[p].cycles; c++) begin
                cycle(tbl[p].wr, tbl[p].rd, tbl[p].din);
            end
            check($sformatf("phase%0d_cnt", p), int'(fifo_cnt), tbl[p].exp_cnt);
            check($sformatf("phase%0d_dout", p), int'(data_out), int'(tbl[p].exp_dout));
        end

        // Simultaneous read/write on empty: write only, data_out unchanged.
        cycle(1'b1, 1'b1, 8'd99);
        check("empty_rw_cnt", int'(fifo_cnt), 1);
        check("empty_rw_dout", int'(data_out), 87);
        cycle(1'b0, 1'b1, 8'd0);
        check("empty_rw_read", int'(data_out), 99);

        // Fill with 10..17, then read+write while full with data 1..4.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(10 + i));
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 8'(1 + i));
            check("full_rw_dout", int'(data_out), 10 + i);
            check("full_rw_cnt", int'(fifo_cnt), 8);
        end
        // Drain: 14..17 then 1..4.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 8'd0);
            check("drain_dout", int'(data_out), (i < 4) ? 14 + i : i - 3);
        end
        check("drain_empty", int'(empty), 1);

        // Mid-stream reset with requests held high: reset wins.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(200 + i));
        cycle(1'b0, 1'b1, 8'd0);
        do_reset(1, 1'b1, 1'b1);
        check("rst_cnt", int'(fifo_cnt), 0);
        check("rst_dout", int'(data_out), 0);
        check("rst_empty", int'(empty), 1);
        // Stored entries were discarded: a read now is rejected.
        cycle(1'b0, 1'b1, 8'd0);
        check("post_rst_dout", int'(data_out), 0);
        cycle(1'b1, 1'b0, 8'd77);
        cycle(1'b0, 1'b1, 8'd0);
        check("post_rst_read", int'(data_out), 77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo.md
# fifo

Synchronous single-clock first-in/first-out buffer. It holds up to 8 bytes written by a producer and returns them in order to a consumer. Fill status is reported through `empty`, `full` and an occupancy count. It serves as the general-purpose byte queue between two blocks in the same clock domain.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of each entry.
- `DEPTH`, 8, number of entries; must be a power of two.
- `CNT_WIDTH`, 4, width of `fifo_cnt`; must be at least log2(DEPTH)+1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr`  in  1  write request; `data_in` is enqueued on this edge if the FIFO is not full.
- `data_in`  in  DATA_WIDTH  write data.
- `rd`  in  1  read request; the head entry is dequeued on this edge if the FIFO is not empty.
- `data_out`  out  DATA_WIDTH  registered read data.
- `empty`  out  1  high when `fifo_cnt == 0`.
- `full`  out  1  high when `fifo_cnt == DEPTH`.
- `fifo_cnt`  out  CNT_WIDTH  number of stored entries, 0..DEPTH.

## Operation
- Storage is a DEPTH-entry register array with write pointer `wr_ptr` and read pointer `rd_ptr`, each log2(DEPTH) bits wide.
- Pointers wrap modulo DEPTH through natural overflow. The array contents are not reset.
- An accepted write stores `data_in` at `mem[wr_ptr]` and increments `wr_ptr`. A write is accepted when `wr && !full`, or when `wr && rd && full`.
- An accepted read loads `mem[rd_ptr]` into `data_out` and increments `rd_ptr`. A read is accepted when `rd && !empty`.
- Rejected requests have no effect: no pointer change, no count change, no memory write.
- `data_out` holds its last value when no read is accepted, including while empty.
- Simultaneous `rd` and `wr`:
  - When empty: the write is accepted, the read is rejected, and the count rises by 1.
  - When full: both are accepted and the count is unchanged. The read returns the oldest entry, and the write fills the freed slot.
  - Otherwise: both are accepted and the count is unchanged.
- `fifo_cnt` updates as +1 for write-only, -1 for read-only, and 0 for both or neither. It never goes below 0 or above DEPTH.

## Timing
- Reset on a rising edge with `rst=1` sets `wr_ptr=0`, `rd_ptr=0`, `fifo_cnt=0`, `data_out=0`, `empty=1`, `full=0`. Reset overrides `rd` and `wr` in the same cycle.
- A reset asserted mid-operation discards all stored entries.
- Read latency is one cycle: for a read accepted at edge N, the data is valid on `data_out` after edge N.
- `empty`, `full` and `fifo_cnt` reflect all requests accepted at edge N immediately after edge N. Flags are decoded from the count register, so they are glitch-free.
- A write accepted at edge N is readable from edge N+1.

## Configuration
- Macro `FIFO_ERR_FLAGS_EN`.
- When defined, two extra outputs are added:
  - `overflow` (1 bit) is a registered one-cycle pulse after an edge where `wr` was rejected because the FIFO was full.
  - `underflow` (1 bit) is a registered one-cycle pulse after an edge where `rd` was rejected because the FIFO was empty.
  - Both reset to 0.
- When undefined, these ports and their logic do not exist. All other behaviour is identical in both builds.

## Test plan
- Reset for 2 cycles, then idle for 10 cycles -> `empty=1`, `full=0`, `fifo_cnt=0`, `data_out=0` throughout.
- `wr=1` with `data_in=42` for 20 cycles -> count climbs 1..8 and `full=1` after the 8th edge. The remaining 12 writes are dropped (`overflow` pulses when enabled).
- Then `rd=1` for 10 cycles -> `data_out=42` for 8 reads and count falls to 0 with `empty=1`. The last 2 reads are rejected and `data_out` stays 42.
- Write 30 for 15 cycles (full with 8×30), then write 55 for 10 cycles (all dropped), then read for 5 cycles -> `data_out` gives 30 five times and `fifo_cnt=3`.
- Write 87 for 25 cycles -> full after 5 accepted writes. Then read for 15 cycles -> outputs 30, 30, 30, 87, 87, 87, 87, 87, then `empty=1` with `data_out` holding 87.
- When full, hold `rd=1` and `wr=1` for 4 cycles with data 1..4 -> oldest entries come out in order, count stays 8, and data 1..4 appear after the prior 4 remaining entries. Asserting `rst` mid-stream clears the count to 0 on the next edge.
